// File: rtl/auc_naf_seq_if.sv
// auc_naf_seq_if: digit-stream, point-command and sequence-status signals of the NAF sequencer.
interface auc_naf_seq_if #(parameter int WINDOW = 4);
    localparam int DIG_W = (1 << (WINDOW - 2)) + 1;
    localparam int IDX_W = WINDOW - 2;
    logic             seq_start;
    logic             naf_shft_rdy;
    logic [DIG_W-1:0] naf_shft_vlue;
    logic             naf_shft_last;
    logic             naf_shft_en;
    logic             cmd_vld;
    logic [1:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic             cmd_neg;
    logic             cmd_done;
    logic             seq_done;
    logic             seq_inf;
    logic             seq_err;
    modport master (
        output seq_start, naf_shft_rdy, naf_shft_vlue, naf_shft_last, cmd_done,
        input  naf_shft_en, cmd_vld, cmd_op, cmd_idx, cmd_neg, seq_done, seq_inf, seq_err
    );
    modport slave (
        input  seq_start, naf_shft_rdy, naf_shft_vlue, naf_shft_last, cmd_done,
        output naf_shft_en, cmd_vld, cmd_op, cmd_idx, cmd_neg, seq_done, seq_inf, seq_err
    );
endinterface

// File: rtl/auc_naf_seq.sv
// auc_naf_seq: left-to-right window-NAF double-and-add command sequencer.
// Optional AUC_NAF_SEQ_STAT_EN adds saturating DBL and LOAD/ADD completion counters.
module auc_naf_seq #(
    parameter int WINDOW = 4
`ifdef AUC_NAF_SEQ_STAT_EN
    , parameter int CNT_W = 9
`endif
) (
    input logic clk,
    input logic rst,
    auc_naf_seq_if.slave bus
`ifdef AUC_NAF_SEQ_STAT_EN
    , output logic [CNT_W-1:0] stat_dbl,
    output logic [CNT_W-1:0] stat_add
`endif
);
    localparam int MAG_W = 1 << (WINDOW - 2);
    localparam int IDX_W = WINDOW - 2;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_DBL  = 2'd1;
    localparam logic [1:0] OP_ADD  = 2'd2;

    typedef enum logic [3:0] {IDLE, WAIT, DEC, ISS1, WT1, ISS2, WT2, ADV, GAP, FIN} state_t;

    state_t           state;
    logic [MAG_W-1:0] mag;
    logic             multi;
    logic             nz_c;
    logic [IDX_W-1:0] idx_c;
    logic             sgn;
    logic [IDX_W-1:0] idx;
    logic             nz;
    logic             last;
    logic             q_inf;
    logic [1:0]       op;

    assign mag   = bus.naf_shft_vlue[MAG_W-1:0];
    assign multi = |(mag & (mag - MAG_W'(1)));
    assign nz_c  = |mag && !multi;

    // Magnitude MSB is 1P, so bit i maps to table index MAG_W-1-i.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < MAG_W; i++)
            if (mag[i]) idx_c = IDX_W'(MAG_W - 1 - i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.naf_shft_en <= 1'b0;
            bus.cmd_vld     <= 1'b0;
            bus.cmd_op      <= '0;
            bus.cmd_idx     <= '0;
            bus.cmd_neg     <= 1'b0;
            bus.seq_done    <= 1'b0;
            bus.seq_inf     <= 1'b1;
            bus.seq_err     <= 1'b0;
            q_inf           <= 1'b1;
            sgn             <= 1'b0;
            idx             <= '0;
            nz              <= 1'b0;
            last            <= 1'b0;
            op              <= OP_LOAD;
`ifdef AUC_NAF_SEQ_STAT_EN
            stat_dbl        <= '0;
            stat_add        <= '0;
`endif
        end else begin
            bus.naf_shft_en <= 1'b0;
            bus.seq_done    <= 1'b0;
            case (state)
                IDLE: if (bus.seq_start) begin
                    state       <= WAIT;
                    q_inf       <= 1'b1;
                    bus.seq_err <= 1'b0;
`ifdef AUC_NAF_SEQ_STAT_EN
                    stat_dbl    <= '0;
                    stat_add    <= '0;
`endif
                end
                WAIT: if (bus.naf_shft_rdy) state <= DEC;
                DEC: begin
                    sgn   <= bus.naf_shft_vlue[MAG_W];
                    idx   <= idx_c;
                    nz    <= nz_c;
                    last  <= bus.naf_shft_last;
                    op    <= q_inf ? OP_LOAD : OP_DBL;
                    state <= (q_inf && !nz_c) ? ADV : ISS1;
                    if (multi) bus.seq_err <= 1'b1;
                end
                ISS1: begin
                    bus.cmd_vld <= 1'b1;
                    bus.cmd_op  <= op;
                    bus.cmd_idx <= idx;
                    bus.cmd_neg <= sgn;
                    state       <= WT1;
                end
                // Q is finite after any completed command, so q_inf clears unconditionally.
                WT1: if (bus.cmd_done) begin
                    bus.cmd_vld <= 1'b0;
                    q_inf       <= 1'b0;
                    state       <= (op == OP_DBL && nz) ? ISS2 : ADV;
`ifdef AUC_NAF_SEQ_STAT_EN
                    if (op == OP_DBL && !(&stat_dbl)) stat_dbl <= stat_dbl + CNT_W'(1);
                    if (op != OP_DBL && !(&stat_add)) stat_add <= stat_add + CNT_W'(1);
`endif
                end
                ISS2: begin
                    bus.cmd_vld <= 1'b1;
                    bus.cmd_op  <= OP_ADD;
                    state       <= WT2;
                end
                WT2: if (bus.cmd_done) begin
                    bus.cmd_vld <= 1'b0;
                    state       <= ADV;
`ifdef AUC_NAF_SEQ_STAT_EN
                    if (!(&stat_add)) stat_add <= stat_add + CNT_W'(1);
`endif
                end
                ADV: begin
                    bus.naf_shft_en <= 1'b1;
                    state           <= last ? FIN : GAP;
                end
                GAP: state <= WAIT;
                FIN: begin
                    bus.seq_done <= 1'b1;
                    bus.seq_inf  <= q_inf;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_auc_naf_seq.sv
// tb_auc_naf_seq: table vectors, hand corner sequences and random digit streams for auc_naf_seq.
module tb_auc_naf_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    auc_naf_seq_if #(.WINDOW(4)) bus ();
`ifdef AUC_NAF_SEQ_STAT_EN
    logic [8:0] stat_dbl, stat_add;
`endif
    auc_naf_seq #(.WINDOW(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef AUC_NAF_SEQ_STAT_EN
        , .stat_dbl(stat_dbl),
        .stat_add(stat_add)
`endif
    );

    // Command code: op*100 + idx*10 + neg; DBL is always 100. Digit 99 = illegal 5'b01100.
    typedef struct packed {
        logic [2:0]      n;
        logic [4:0][7:0] d;
        logic [2:0]      nc;
        logic [5:0][7:0] c;
        logic            inf;
        logic            err;
    } vec_t;

    int pass_n = 0, total_n = 0;
    int dg[$], cmds[$], exp_c[$];
    bit exp_inf, exp_err, busy, hold, got_inf, got_err;
    int lat, start_at, nstep, done_step, rk, en_cnt, viol, wcnt, cur;
    vec_t tbl[6];

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        total_n++;
        if (ok) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(int n, int d0, int d1, int d2, int d3, int d4, int nc,
                                int c0, int c1, int c2, int c3, int c4, int c5, bit inf, bit err);
        vec_t r;
        r.n = 3'(n); r.nc = 3'(nc); r.inf = inf; r.err = err;
        r.d[0] = 8'(d0); r.d[1] = 8'(d1); r.d[2] = 8'(d2); r.d[3] = 8'(d3); r.d[4] = 8'(d4);
        r.c[0] = 8'(c0); r.c[1] = 8'(c1); r.c[2] = 8'(c2); r.c[3] = 8'(c3); r.c[4] = 8'(c4); r.c[5] = 8'(c5);
        return r;
    endfunction

    function automatic logic [4:0] enc(int d);
        logic [3:0] oh;
        int m;
        oh = 4'b1000;
        if (d == 99) return 5'b01100;
        if (d == 0) return 5'b00000;
        m = d < 0 ? -d : d;
        oh = oh >> ((m - 1) / 2);
        return {d < 0, oh};
    endfunction

    task automatic present();
        if (rk < dg.size()) begin
            bus.naf_shft_rdy  = 1'b1;
            bus.naf_shft_vlue = enc(dg[rk]);
            bus.naf_shft_last = (rk == dg.size() - 1);
        end else begin
            bus.naf_shft_rdy  = 1'b0;
            bus.naf_shft_vlue = '0;
            bus.naf_shft_last = 1'b0;
        end
    endtask

    // One cycle: observe DUT, act as datapath (fixed latency lat), act as recoder.
    task automatic step();
        int code;
        @(negedge clk);
        nstep++;
        if (bus.naf_shft_en) begin
            en_cnt++;
            rk++;
            if (bus.cmd_vld) viol++;
        end
        if (bus.seq_done && done_step < 0) begin
            done_step = nstep;
            got_inf   = bus.seq_inf;
            got_err   = bus.seq_err;
        end
        if (bus.cmd_done) bus.cmd_done = 1'b0;
        else if (bus.cmd_vld && !hold) begin
            code = bus.cmd_op == 2'd1 ? 100 :
                   int'(bus.cmd_op) * 100 + int'(bus.cmd_idx) * 10 + int'(bus.cmd_neg);
            if (!busy) begin
                busy = 1'b1; cur = code; wcnt = lat;
            end else chk(code == cur, "cmd_stable", code, cur);
            if (wcnt == 0) begin
                bus.cmd_done = 1'b1;
                cmds.push_back(cur);
                busy = 1'b0;
            end else wcnt--;
        end
        bus.seq_start = (nstep == start_at);
        present();
    endtask

    task automatic begin_run(input int l, input int sa);
        lat = l; start_at = sa; cmds.delete();
        rk = 0; busy = 0; done_step = -1; nstep = 0; en_cnt = 0; viol = 0;
        present();
        bus.seq_start = 1'b1;
    endtask

    task automatic run(input int l, input int sa);
        begin_run(l, sa);
        while (done_step < 0 && nstep < 600) step();
    endtask

    // Reference: leading zeros issue nothing, first nonzero LOADs, every later digit DBLs then ADDs if nonzero.
    task automatic model();
        bit started;
        int v, m;
        started = 0; exp_err = 0; exp_c.delete();
        foreach (dg[i]) begin
            v = dg[i];
            if (v == 99) begin exp_err = 1; v = 0; end
            if (started) exp_c.push_back(100);
            if (v != 0) begin
                m = v < 0 ? -v : v;
                exp_c.push_back((started ? 200 : 0) + ((m - 1) / 2) * 10 + (v < 0 ? 1 : 0));
                started = 1;
            end
        end
        exp_inf = !started;
    endtask

    task automatic from_table(input vec_t r);
        dg.delete(); exp_c.delete();
        for (int i = 0; i < int'(r.n); i++) dg.push_back(int'($signed(r.d[i])));
        for (int i = 0; i < int'(r.nc); i++) exp_c.push_back(int'(r.c[i]));
        exp_inf = r.inf; exp_err = r.err;
    endtask

    task automatic verify(input string tag);
        int q, want, dv, d, op, nd;
        chk(done_step >= 0, {tag, "/seq_done"}, done_step, 1);
        chk(cmds.size() == exp_c.size(), {tag, "/ncmd"}, cmds.size(), exp_c.size());
        for (int i = 0; i < cmds.size() && i < exp_c.size(); i++)
            chk(cmds[i] == exp_c[i], {tag, "/cmd"}, cmds[i], exp_c[i]);
        chk(got_inf == exp_inf, {tag, "/seq_inf"}, got_inf, exp_inf);
        chk(got_err == exp_err, {tag, "/seq_err"}, got_err, exp_err);
        chk(en_cnt == dg.size(), {tag, "/shft_en"}, en_cnt, dg.size());
        chk(viol == 0, {tag, "/en_during_vld"}, viol, 0);
        want = 1 + 4 * dg.size() + (2 + lat) * exp_c.size();
        chk(done_step == want, {tag, "/cycles"}, done_step, want);
        q = 0; want = 0; nd = 0;
        foreach (dg[i]) want = want * 2 + (dg[i] == 99 ? 0 : dg[i]);
        foreach (cmds[i]) begin
            op = cmds[i] / 100;
            d  = (2 * ((cmds[i] / 10) % 10) + 1) * ((cmds[i] % 10) != 0 ? -1 : 1);
            q  = op == 0 ? d : op == 1 ? q * 2 : q + d;
            if (op == 1) nd++;
        end
        chk(q == want, {tag, "/scalar"}, q, want);
`ifdef AUC_NAF_SEQ_STAT_EN
        chk(int'(stat_dbl) == nd, {tag, "/stat_dbl"}, int'(stat_dbl), nd);
        chk(int'(stat_add) == cmds.size() - nd, {tag, "/stat_add"}, int'(stat_add), cmds.size() - nd);
`else
        dv = nd;
`endif
    endtask

    initial begin
        int n, r, d;
        tbl[0] = mk(1, 7, 0, 0, 0, 0,   1, 30, 0, 0, 0, 0, 0,          0, 0);
        tbl[1] = mk(5, 1, 0, 0, 0, -3,  6, 0, 100, 100, 100, 100, 211, 0, 0);
        tbl[2] = mk(2, 99, 3, 0, 0, 0,  1, 10, 0, 0, 0, 0, 0,          0, 1);
        tbl[3] = mk(3, 0, 0, 5, 0, 0,   1, 20, 0, 0, 0, 0, 0,          0, 0);
        tbl[4] = mk(3, 1, 99, -1, 0, 0, 4, 0, 100, 100, 201, 0, 0,     0, 1);
        tbl[5] = mk(3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,           1, 0);

        bus.seq_start = 0; bus.cmd_done = 0; hold = 0;
        dg.delete(); rk = 0; lat = 0; start_at = -1; nstep = 0; done_step = -1;
        present();
        repeat (3) step();
        chk(bus.naf_shft_en == 0, "rst/shft_en", bus.naf_shft_en, 0);
        chk(bus.cmd_vld == 0, "rst/cmd_vld", bus.cmd_vld, 0);
        chk(bus.seq_done == 0, "rst/seq_done", bus.seq_done, 0);
        chk(bus.seq_err == 0, "rst/seq_err", bus.seq_err, 0);
        chk(bus.seq_inf == 1, "rst/seq_inf", bus.seq_inf, 1);
        chk({bus.cmd_op, bus.cmd_idx, bus.cmd_neg} == 5'd0, "rst/cmd_fields",
            {bus.cmd_op, bus.cmd_idx, bus.cmd_neg}, 0);
        rst = 0;
        step();

        for (int i = 0; i < 6; i++) begin
            from_table(tbl[i]);
            run(i % 3, -1);
            verify($sformatf("tbl%0d", i));
        end

        // seq_start mid-run must be ignored, so the sticky error survives.
        dg = '{99, 0, 1};
        model();
        run(2, 6);
        verify("start_busy");

        // Reset while a command is outstanding, with a simultaneous cmd_done.
        dg = '{7};
        hold = 1;
        begin_run(0, -1);
        for (int c = 0; c < 20 && !bus.cmd_vld; c++) step();
        chk(bus.cmd_vld == 1, "rst_mid/reach_wt1", bus.cmd_vld, 1);
        rst = 1; bus.cmd_done = 1;
        step();
        chk(bus.cmd_vld == 0, "rst_mid/cmd_vld", bus.cmd_vld, 0);
        chk(bus.seq_inf == 1, "rst_mid/seq_inf", bus.seq_inf, 1);
        chk(bus.cmd_op == 2'd0, "rst_mid/cmd_op", bus.cmd_op, 0);
        rst = 0;
        step();
        bus.cmd_done = 1;
        repeat (3) step();
        chk(bus.cmd_vld == 0 && done_step < 0 && en_cnt == 0, "rst_mid/stray_done",
            {bus.cmd_vld, done_step < 0, en_cnt == 0}, 3'b010 + 3'b001);
        hold = 0;
        dg = '{1, 0, 0, 0, -3};
        model();
        run(1, -1);
        verify("after_rst");

        for (int t = 0; t < 40; t++) begin
            dg.delete();
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                r = int'($urandom_range(0, 99));
                d = (2 * int'($urandom_range(0, 3)) + 1) * ($urandom_range(0, 1) != 0 ? -1 : 1);
                dg.push_back(r < 40 ? 0 : r < 45 ? 99 : d);
            end
            model();
            run(int'($urandom_range(0, 3)), -1);
            verify($sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
